// File: rtl/fast_square_comb_decim_if.sv
// ---------------------------------------------------------------------------
// fast_square_comb_decim_if
//
// Purpose: groups the sample-stream signals of the fast-square I/Q comb
// decimator into one bundle. The producer side (DDC output plus the
// freq_step restart source) uses the master modport. The comb/decimator
// uses the slave modport.
//
// Signals:
//   in_strobe   producer -> decim  i_in/q_in valid this cycle
//   restart     producer -> decim  one-cycle synchronous re-initialise
//   i_in, q_in  producer -> decim  signed WIDTH-bit input samples
//   out_strobe  decim -> consumer  one-cycle pulse, i_out/q_out updated
//   i_out/q_out decim -> consumer  signed WIDTH-bit decimated samples
//   blanking    decim -> consumer  high while outputs are forced to blank
// ---------------------------------------------------------------------------
interface fast_square_comb_decim_if #(
    parameter int WIDTH = 16
);
    logic                    in_strobe;
    logic                    restart;
    logic signed [WIDTH-1:0] i_in;
    logic signed [WIDTH-1:0] q_in;
    logic                    out_strobe;
    logic signed [WIDTH-1:0] i_out;
    logic signed [WIDTH-1:0] q_out;
    logic                    blanking;

    // Sample source / testbench side
    modport master (
        output in_strobe,
        output restart,
        output i_in,
        output q_in,
        input  out_strobe,
        input  i_out,
        input  q_out,
        input  blanking
    );

    // Comb/decimator side
    modport slave (
        input  in_strobe,
        input  restart,
        input  i_in,
        input  q_in,
        output out_strobe,
        output i_out,
        output q_out,
        output blanking
    );
endinterface

// File: rtl/fast_square_comb_decim.sv
// ---------------------------------------------------------------------------
// fast_square_comb_decim
//
// Purpose: parametrised I/Q comb filter followed by a decimator for the
// fast-square baseband path. It sits between the DDC output and the
// baseband capture/record logic. After reset or restart, the first
// BLANK_OUTPUTS decimated outputs are replaced by BLANK_VALUE, so the
// recorder never sees the comb settling transient.
//
// Ports:
//   clock  sole clock; all state updates on the rising edge
//   reset  asynchronous, active-low; clears all state
//   bus    slave side of fast_square_comb_decim_if:
//            in_strobe/i_in/q_in  input sample stream
//            restart              synchronous re-initialise (e.g. freq_step)
//            out_strobe           one-cycle pulse with new i_out/q_out
//            i_out/q_out          registered saturated outputs, held
//            blanking             high while outputs are forced to blank
//
// Parameters:
//   WIDTH          sample width in and out (signed)
//   STAGES         cascaded comb stages, 1..4
//   DELAY          comb differential delay D, 1..4
//   DECIM          decimation factor, 1..255
//   BLANK_OUTPUTS  decimated outputs blanked after reset/restart, 0..65535
//   BLANK_VALUE    value driven while blanking
// ---------------------------------------------------------------------------
module fast_square_comb_decim #(
    parameter int               WIDTH         = 16,
    parameter int               STAGES        = 2,
    parameter int               DELAY         = 1,
    parameter int               DECIM         = 17,
    parameter int               BLANK_OUTPUTS = 201,
    parameter logic [WIDTH-1:0] BLANK_VALUE   = 16'h8000
) (
    input  logic                       clock,
    input  logic                       reset,
    fast_square_comb_decim_if.slave    bus
);

    // Widest intermediate value: stage k grows the word by one bit.
    localparam int WW = WIDTH + STAGES;

    localparam logic [7:0]  DECIM_M1 = 8'(DECIM - 1);
    localparam logic [15:0] BLANK_N  = 16'(BLANK_OUTPUTS);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // With no outputs to blank, the block comes out of reset already running.
    localparam state_t ST_INIT = (BLANK_OUTPUTS == 0) ? ST_RUN : ST_BLANK;

    // -----------------------------------------------------------------------
    // Comb chain
    // Element 0 is the (sign-extended) input. Element k is the output of
    // stage k. All elements share the widest format so that the generate
    // loop can index them uniformly. Each stage only consumes the low bits
    // that its true width needs.
    // -----------------------------------------------------------------------
    logic signed [WW-1:0] i_chain [0:STAGES];
    logic signed [WW-1:0] q_chain [0:STAGES];
    logic [STAGES:0]      v_chain;

    // A sample presented together with restart is discarded.
    assign v_chain[0] = bus.in_strobe & ~bus.restart;
    assign i_chain[0] = WW'(bus.i_in);
    assign q_chain[0] = WW'(bus.q_in);

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int IW = WIDTH + gi;   // input width of this stage
        localparam int OW = IW + 1;       // output width of this stage

        logic signed [IW-1:0] i_x;
        logic signed [IW-1:0] q_x;
        logic signed [IW-1:0] i_dl_q [0:DELAY-1];
        logic signed [IW-1:0] q_dl_q [0:DELAY-1];
        logic signed [OW-1:0] i_y_d;
        logic signed [OW-1:0] q_y_d;
        logic signed [OW-1:0] i_y_q;
        logic signed [OW-1:0] q_y_q;
        logic                 v_q;

        // The upper bits of the shared-width chain are pure sign extension.
        assign i_x = i_chain[gi][IW-1:0];
        assign q_x = q_chain[gi][IW-1:0];

        // y[n] = x[n] - x[n-D], with a one-bit sign extension so it is exact.
        assign i_y_d = {i_x[IW-1], i_x} - {i_dl_q[DELAY-1][IW-1], i_dl_q[DELAY-1]};
        assign q_y_d = {q_x[IW-1], q_x} - {q_dl_q[DELAY-1][IW-1], q_dl_q[DELAY-1]};

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int j = 0; j < DELAY; j++) begin
                    i_dl_q[j] <= '0;
                    q_dl_q[j] <= '0;
                end
                i_y_q <= '0;
                q_y_q <= '0;
                v_q   <= 1'b0;
            end else if (bus.restart) begin
                for (int j = 0; j < DELAY; j++) begin
                    i_dl_q[j] <= '0;
                    q_dl_q[j] <= '0;
                end
                i_y_q <= '0;
                q_y_q <= '0;
                v_q   <= 1'b0;
            end else begin
                // The valid bit is a pulse. Data and history only move on
                // valid, so input gaps stall the chain without losing anything.
                v_q <= v_chain[gi];
                if (v_chain[gi]) begin
                    i_dl_q[0] <= i_x;
                    q_dl_q[0] <= q_x;
                    for (int j = 1; j < DELAY; j++) begin
                        i_dl_q[j] <= i_dl_q[j-1];
                        q_dl_q[j] <= q_dl_q[j-1];
                    end
                    i_y_q <= i_y_d;
                    q_y_q <= q_y_d;
                end
            end
        end

        assign i_chain[gi+1] = WW'(i_y_q);
        assign q_chain[gi+1] = WW'(q_y_q);
        assign v_chain[gi+1] = v_q;
    end

    // -----------------------------------------------------------------------
    // Saturation of the last comb stage down to the output width.
    // The value fits when all bits from the output sign bit upwards agree.
    // -----------------------------------------------------------------------
    function automatic logic signed [WIDTH-1:0] sat_out(input logic signed [WW-1:0] v);
        logic [STAGES:0] top;
        top = v[WW-1:WIDTH-1];
        if ((top == '0) || (top == '1)) begin
            sat_out = v[WIDTH-1:0];
        end else if (v[WW-1]) begin
            sat_out = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sat_out = {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    logic signed [WIDTH-1:0] i_sat;
    logic signed [WIDTH-1:0] q_sat;

    assign i_sat = sat_out(i_chain[STAGES]);
    assign q_sat = sat_out(q_chain[STAGES]);

    // -----------------------------------------------------------------------
    // Decimation and blanking control
    // BLANK counts blanked strobes in bcnt. The strobe that brings bcnt to
    // BLANK_OUTPUTS still carries BLANK_VALUE, but it moves the machine to
    // RUN, so blanking drops in the same cycle as that strobe. bcnt
    // saturates because it only advances while in BLANK.
    // -----------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [7:0]              dcnt_q, dcnt_d;
    logic [15:0]             bcnt_q, bcnt_d;
    logic                    out_strobe_q, out_strobe_d;
    logic signed [WIDTH-1:0] i_out_q, i_out_d;
    logic signed [WIDTH-1:0] q_out_q, q_out_d;

    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        bcnt_d       = bcnt_q;
        out_strobe_d = 1'b0;
        i_out_d      = i_out_q;
        q_out_d      = q_out_q;

        if (bus.restart) begin
            // Restart wins over any capture that would land this cycle.
            state_d = ST_INIT;
            dcnt_d  = '0;
            bcnt_d  = '0;
            i_out_d = BLANK_VALUE;
            q_out_d = BLANK_VALUE;
        end else if (v_chain[STAGES]) begin
            if (dcnt_q == DECIM_M1) begin
                dcnt_d       = '0;
                out_strobe_d = 1'b1;
                if (state_q == ST_BLANK) begin
                    i_out_d = BLANK_VALUE;
                    q_out_d = BLANK_VALUE;
                    bcnt_d  = bcnt_q + 16'd1;
                    if (bcnt_d == BLANK_N) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    i_out_d = i_sat;
                    q_out_d = q_sat;
                end
            end else begin
                dcnt_d = dcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            dcnt_q       <= '0;
            bcnt_q       <= '0;
            out_strobe_q <= 1'b0;
            i_out_q      <= BLANK_VALUE;
            q_out_q      <= BLANK_VALUE;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            bcnt_q       <= bcnt_d;
            out_strobe_q <= out_strobe_d;
            i_out_q      <= i_out_d;
            q_out_q      <= q_out_d;
        end
    end

    assign bus.out_strobe = out_strobe_q;
    assign bus.i_out      = i_out_q;
    assign bus.q_out      = q_out_q;
    assign bus.blanking   = (state_q == ST_BLANK);

endmodule

// File: tb/tb_fast_square_comb_decim.sv
// ---------------------------------------------------------------------------
// tb_fast_square_comb_decim
//
// Three instances share one clock:
//   dut_a  STAGES=2 D=1 DECIM=17 BLANK_OUTPUTS=3  (blanking / first strobe)
//   dut_b  STAGES=2 D=1 DECIM=1  BLANK_OUTPUTS=0  (impulse, saturation)
//   dut_c  STAGES=2 D=1 DECIM=4  BLANK_OUTPUTS=1  (sparse input, restart,
//                                                  async reset)
// The negedge monitors log every out_strobe with its cycle number, and the
// directed tests compare the logs against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_fast_square_comb_decim;

    localparam int W  = 16;
    localparam int BV = -32768;   // BLANK_VALUE 16'h8000 read as signed

    typedef struct {
        int c;
        int i;
        int q;
        int b;
    } strobe_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n, rst_c_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   t0;

    // Hand-computed second difference of the impulse 100,0,0,...
    int exp_imp [6] = '{100, -200, 100, 0, 0, 0};

    strobe_t mon_a[$];
    strobe_t mon_b[$];
    strobe_t mon_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    fast_square_comb_decim_if #(.WIDTH(W)) bus_a ();
    fast_square_comb_decim_if #(.WIDTH(W)) bus_b ();
    fast_square_comb_decim_if #(.WIDTH(W)) bus_c ();

    fast_square_comb_decim #(
        .WIDTH(W), .STAGES(2), .DELAY(1), .DECIM(17),
        .BLANK_OUTPUTS(3), .BLANK_VALUE(16'h8000)
    ) dut_a (.clock(clk), .reset(rst_a_n), .bus(bus_a));

    fast_square_comb_decim #(
        .WIDTH(W), .STAGES(2), .DELAY(1), .DECIM(1),
        .BLANK_OUTPUTS(0), .BLANK_VALUE(16'h8000)
    ) dut_b (.clock(clk), .reset(rst_b_n), .bus(bus_b));

    fast_square_comb_decim #(
        .WIDTH(W), .STAGES(2), .DELAY(1), .DECIM(4),
        .BLANK_OUTPUTS(1), .BLANK_VALUE(16'h8000)
    ) dut_c (.clock(clk), .reset(rst_c_n), .bus(bus_c));

    always @(negedge clk) begin
        strobe_t s;
        if (bus_a.out_strobe === 1'b1) begin
            s.c = cyc; s.i = 32'(bus_a.i_out); s.q = 32'(bus_a.q_out); s.b = 32'(bus_a.blanking);
            mon_a.push_back(s);
        end
    end

    always @(negedge clk) begin
        strobe_t s;
        if (bus_b.out_strobe === 1'b1) begin
            s.c = cyc; s.i = 32'(bus_b.i_out); s.q = 32'(bus_b.q_out); s.b = 32'(bus_b.blanking);
            mon_b.push_back(s);
        end
    end

    always @(negedge clk) begin
        strobe_t s;
        if (bus_c.out_strobe === 1'b1) begin
            s.c = cyc; s.i = 32'(bus_c.i_out); s.q = 32'(bus_c.q_out); s.b = 32'(bus_c.blanking);
            mon_c.push_back(s);
        end
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_strobe(input string tag, input strobe_t s, input int ec,
                                input int ei, input int eq, input int eb);
        check($sformatf("%s_cyc", tag), s.c, ec);
        check($sformatf("%s_i", tag),   s.i, ei);
        check($sformatf("%s_q", tag),   s.q, eq);
        check($sformatf("%s_blank", tag), s.b, eb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.in_strobe = 1'b0; bus_a.restart = 1'b0; bus_a.i_in = '0; bus_a.q_in = '0;
        bus_b.in_strobe = 1'b0; bus_b.restart = 1'b0; bus_b.i_in = '0; bus_b.q_in = '0;
        bus_c.in_strobe = 1'b0; bus_c.restart = 1'b0; bus_c.i_in = '0; bus_c.q_in = '0;
        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;

        // ---------------- reset values ----------------
        #12;
        check("A_rst_strobe", 32'(bus_a.out_strobe), 0);
        check("A_rst_i",      32'(bus_a.i_out), BV);
        check("A_rst_q",      32'(bus_a.q_out), BV);
        check("A_rst_blank",  32'(bus_a.blanking), 1);
        check("B_rst_blank",  32'(bus_b.blanking), 0);
        check("B_rst_i",      32'(bus_b.i_out), BV);
        check("C_rst_blank",  32'(bus_c.blanking), 1);
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
        tick(); tick();

        // ---------------- A: constant input, DECIM=17, 3 blanked ----------------
        mon_a.delete();
        t0 = cyc;
        bus_a.in_strobe = 1'b1; bus_a.i_in = 16'sd100; bus_a.q_in = -16'sd50;
        repeat (104) tick();
        bus_a.in_strobe = 1'b0;
        repeat (4) tick();
        check("A_nstrobe", mon_a.size(), 6);
        for (int k = 0; k < mon_a.size() && k < 6; k++)
            check_strobe($sformatf("A_s%0d", k), mon_a[k], t0 + 19 + 17 * k,
                         (k < 3) ? BV : 0, (k < 3) ? BV : 0, (k < 2) ? 1 : 0);
        check("A_blank_after", 32'(bus_a.blanking), 0);

        // ---------------- B: impulse response, DECIM=1 ----------------
        mon_b.delete();
        t0 = cyc;
        for (int s = 0; s < 6; s++) begin
            bus_b.in_strobe = 1'b1;
            bus_b.i_in = (s == 0) ? 16'sd100 : 16'sd0;
            bus_b.q_in = 16'sd0;
            tick();
        end
        bus_b.in_strobe = 1'b0;
        repeat (5) tick();
        check("B_imp_nstrobe", mon_b.size(), 6);
        for (int k = 0; k < mon_b.size() && k < 6; k++)
            check_strobe($sformatf("B_imp%0d", k), mon_b[k], t0 + k + 3, exp_imp[k], 0, 0);

        // ---------------- B: saturation ----------------
        bus_b.restart = 1'b1;
        tick();
        bus_b.restart = 1'b0;
        check("B_restart_i", 32'(bus_b.i_out), BV);
        mon_b.delete();
        t0 = cyc;
        for (int s = 0; s < 8; s++) begin
            bus_b.in_strobe = 1'b1;
            bus_b.i_in = (s % 2 == 0) ? 16'sd32767 : -16'sd32768;
            bus_b.q_in = 16'sd0;
            tick();
        end
        bus_b.in_strobe = 1'b0;
        repeat (5) tick();
        check("B_sat_nstrobe", mon_b.size(), 8);
        for (int k = 0; k < mon_b.size() && k < 8; k++)
            check_strobe($sformatf("B_sat%0d", k), mon_b[k], t0 + k + 3,
                         (k % 2 == 0) ? 32767 : -32768, 0, 0);

        // ---------------- C: sparse input (every 3rd cycle), x[n]=n*n ----------------
        mon_c.delete();
        t0 = cyc;
        for (int n = 0; n < 12; n++) begin
            bus_c.in_strobe = 1'b1;
            bus_c.i_in = 16'(n * n);
            bus_c.q_in = 16'(-(n * n));
            tick();
            bus_c.in_strobe = 1'b0;
            tick(); tick();
        end
        repeat (5) tick();
        check("C_sparse_nstrobe", mon_c.size(), 3);
        for (int k = 0; k < mon_c.size() && k < 3; k++)
            check_strobe($sformatf("C_sp%0d", k), mon_c[k], t0 + 12 * (k + 1),
                         (k == 0) ? BV : 2, (k == 0) ? BV : -2, 0);

        // ---------------- C: restart with in_strobe, colliding with a capture ----------------
        mon_c.delete();
        t0 = cyc;
        for (int s = 0; s < 5; s++) begin
            bus_c.in_strobe = 1'b1; bus_c.i_in = 16'sd100; bus_c.q_in = 16'sd100;
            tick();
        end
        bus_c.in_strobe = 1'b1; bus_c.restart = 1'b1; bus_c.i_in = 16'sd999; bus_c.q_in = 16'sd999;
        tick();
        bus_c.restart = 1'b0;
        check("C_rs_strobe", 32'(bus_c.out_strobe), 0);
        check("C_rs_i",      32'(bus_c.i_out), BV);
        check("C_rs_blank",  32'(bus_c.blanking), 1);
        for (int m = 0; m < 8; m++) begin
            bus_c.in_strobe = 1'b1;
            bus_c.i_in = 16'(m * m);
            bus_c.q_in = 16'(-(m * m));
            tick();
        end
        bus_c.in_strobe = 1'b0;
        repeat (5) tick();
        check("C_rs_nstrobe", mon_c.size(), 2);
        for (int k = 0; k < mon_c.size() && k < 2; k++)
            check_strobe($sformatf("C_rs%0d", k), mon_c[k], t0 + 12 + 4 * k,
                         (k == 0) ? BV : 2, (k == 0) ? BV : -2, 0);

        // ---------------- C: asynchronous reset during a strobe ----------------
        t0 = cyc;
        for (int m = 8; m < 14; m++) begin
            bus_c.in_strobe = 1'b1;
            bus_c.i_in = 16'(m * m);
            bus_c.q_in = 16'(-(m * m));
            tick();
        end
        check("C_pre_strobe", 32'(bus_c.out_strobe), 1);
        check("C_pre_i",      32'(bus_c.i_out), 2);
        bus_c.i_in = 16'(14 * 14);
        bus_c.q_in = 16'(-(14 * 14));
        #2;
        rst_c_n = 1'b0;
        #1;
        check("C_ar_strobe", 32'(bus_c.out_strobe), 0);
        check("C_ar_i",      32'(bus_c.i_out), BV);
        check("C_ar_q",      32'(bus_c.q_out), BV);
        check("C_ar_blank",  32'(bus_c.blanking), 1);
        mon_c.delete();
        bus_c.in_strobe = 1'b0;
        #2;
        rst_c_n = 1'b1;
        tick();
        t0 = cyc;
        for (int n = 0; n < 8; n++) begin
            bus_c.in_strobe = 1'b1;
            bus_c.i_in = 16'(n * n);
            bus_c.q_in = 16'(-(n * n));
            tick();
        end
        bus_c.in_strobe = 1'b0;
        repeat (5) tick();
        check("C_ar_nstrobe", mon_c.size(), 2);
        for (int k = 0; k < mon_c.size() && k < 2; k++)
            check_strobe($sformatf("C_ar%0d", k), mon_c[k], t0 + 6 + 4 * k,
                         (k == 0) ? BV : 2, (k == 0) ? BV : -2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
